// File: rtl/score_scheduler.sv
// Game score/time/high-score controller feeding the 4-digit score_display block.
// A three-state game FSM picks the displayed value; OVER rotates SCORE/TIME/HIGH pages.
module score_scheduler #(
  parameter int DWELL_TICKS = 2,
  parameter int SCORE_MAX   = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_tick,
  input  logic        start,
  input  logic        game_over,
  input  logic        add_valid,
  input  logic [7:0]  add_value,
  input  logic        show_time,
  output logic        disp_mode,
  output logic [13:0] disp_num1,
  output logic [6:0]  disp_num2,
  output logic        disp_enable,
  output logic [13:0] score,
  output logic [13:0] high_score,
  output logic        new_high,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PG_SCORE = 2'd0,
    PG_TIME  = 2'd1,
    PG_HIGH  = 2'd2
  } page_t;

  localparam logic [14:0] SCORE_MAX_W = 15'(SCORE_MAX);
  localparam logic [3:0]  DWELL_LAST  = 4'(DWELL_TICKS - 1);

  // Sum is formed at 15 bits so a near-ceiling score cannot wrap before the clamp.
  function automatic logic [13:0] sat_add(input logic [13:0] a, input logic [7:0] b);
    logic [14:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    if (sum > SCORE_MAX_W) return SCORE_MAX_W[13:0];
    else                   return sum[13:0];
  endfunction

  function automatic page_t next_page(input page_t p);
    case (p)
      PG_SCORE: return PG_TIME;
      PG_TIME:  return PG_HIGH;
      default:  return PG_SCORE;
    endcase
  endfunction

  state_t      state_q, state_n;
  page_t       page_q, page_n;
  logic [13:0] score_q, score_n;
  logic [13:0] high_q, high_n;
  logic        new_high_q, new_high_n;
  logic [5:0]  sec_q, sec_n;
  logic [6:0]  min_q, min_n;
  logic [3:0]  dwell_q, dwell_n;
  logic        blink_q, blink_n;
  logic        mode_q, mode_n;
  logic [13:0] num1_q, num1_n;
  logic [6:0]  num2_q, num2_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      page_q     <= PG_SCORE;
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      sec_q      <= '0;
      min_q      <= '0;
      dwell_q    <= '0;
      blink_q    <= 1'b1;
      mode_q     <= 1'b1;
      num1_q     <= '0;
      num2_q     <= '0;
    end else begin
      state_q    <= state_n;
      page_q     <= page_n;
      score_q    <= score_n;
      high_q     <= high_n;
      new_high_q <= new_high_n;
      sec_q      <= sec_n;
      min_q      <= min_n;
      dwell_q    <= dwell_n;
      blink_q    <= blink_n;
      mode_q     <= mode_n;
      num1_q     <= num1_n;
      num2_q     <= num2_n;
    end
  end

  // Game FSM, scoring, timer and page rotation.
  always_comb begin
    state_n    = state_q;
    page_n     = page_q;
    score_n    = score_q;
    high_n     = high_q;
    new_high_n = new_high_q;
    sec_n      = sec_q;
    min_n      = min_q;
    dwell_n    = dwell_q;
    blink_n    = blink_q;

    if (start) begin
      state_n    = PLAY;
      score_n    = '0;
      sec_n      = '0;
      min_n      = '0;
      new_high_n = 1'b0;
      blink_n    = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          if (add_valid) score_n = sat_add(score_q, add_value);
          if (sec_tick) begin
            // At 99:59 both fields hold.
            if (sec_q == 6'd59) begin
              if (min_q != 7'd99) begin
                sec_n = '0;
                min_n = min_q + 7'd1;
              end
            end else begin
              sec_n = sec_q + 6'd1;
            end
          end
          if (game_over) begin
            state_n = OVER;
            page_n  = PG_SCORE;
            dwell_n = '0;
            if (score_n > high_q) begin
              high_n     = score_n;
              new_high_n = 1'b1;
            end else begin
              new_high_n = 1'b0;
            end
          end
        end
        OVER: begin
          if (sec_tick) begin
            if (new_high_q) blink_n = ~blink_q;
            if (dwell_q == DWELL_LAST) begin
              dwell_n = '0;
              page_n  = next_page(page_q);
            end else begin
              dwell_n = dwell_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Display selection from next-state values so the registered outputs stay aligned.
  always_comb begin
    mode_n = 1'b1;
    num1_n = high_n;
    num2_n = '0;
    case (state_n)
      PLAY: begin
        if (show_time) begin
          mode_n = 1'b0;
          num1_n = {8'd0, sec_n};
          num2_n = min_n;
        end else begin
          num1_n = score_n;
        end
      end
      OVER: begin
        case (page_n)
          PG_SCORE: num1_n = score_n;
          PG_TIME: begin
            mode_n = 1'b0;
            num1_n = {8'd0, sec_n};
            num2_n = min_n;
          end
          default: num1_n = high_n;
        endcase
      end
      default: ;
    endcase
  end

  assign disp_mode   = mode_q;
  assign disp_num1   = num1_q;
  assign disp_num2   = num2_q;
  assign disp_enable = blink_q;
  assign score       = score_q;
  assign high_score  = high_q;
  assign new_high    = new_high_q;
  assign state       = state_q;

endmodule

// File: tb/tb_score_scheduler.sv
// Scoreboard bench for score_scheduler: directed game scenarios then randomized pulses
// against a behavioural model based on elapsed seconds and ticks spent in OVER.
module tb_score_scheduler;

  localparam int DWELL = 2;
  localparam int SMAX  = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sec_tick = 1'b0;
  logic        start = 1'b0;
  logic        game_over = 1'b0;
  logic        add_valid = 1'b0;
  logic [7:0]  add_value = 8'd0;
  logic        show_time = 1'b0;
  logic        disp_mode;
  logic [13:0] disp_num1;
  logic [6:0]  disp_num2;
  logic        disp_enable;
  logic [13:0] score;
  logic [13:0] high_score;
  logic        new_high;
  logic [1:0]  state;

  score_scheduler #(.DWELL_TICKS(DWELL), .SCORE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .start(start),
    .game_over(game_over), .add_valid(add_valid), .add_value(add_value),
    .show_time(show_time), .disp_mode(disp_mode), .disp_num1(disp_num1),
    .disp_num2(disp_num2), .disp_enable(disp_enable), .score(score),
    .high_score(high_score), .new_high(new_high), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, sc, hi, nh, mode, num1, num2, en;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model state: elapsed seconds as one number, ticks counted since entering OVER.
  int m_st = 0, m_sc = 0, m_hi = 0, m_nh = 0, m_t = 0, m_ot = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_view(input bit sh);
    exp_t e;
    int page;
    e.st = m_st; e.sc = m_sc; e.hi = m_hi; e.nh = m_nh;
    e.mode = 1; e.num1 = m_hi; e.num2 = 0;
    e.en = (m_st == 2 && m_nh == 1) ? (((m_ot % 2) == 0) ? 1 : 0) : 1;
    if (m_st == 1) begin
      if (sh) begin e.mode = 0; e.num2 = m_t / 60; e.num1 = m_t % 60; end
      else e.num1 = m_sc;
    end else if (m_st == 2) begin
      page = (m_ot / DWELL) % 3;
      if (page == 0) e.num1 = m_sc;
      else if (page == 1) begin e.mode = 0; e.num2 = m_t / 60; e.num1 = m_t % 60; end
      else e.num1 = m_hi;
    end
    return e;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit g, input bit a,
                            input int v, input bit t, input bit sh);
    if (r) begin
      m_st = 0; m_sc = 0; m_hi = 0; m_nh = 0; m_t = 0; m_ot = 0;
    end else if (s) begin
      m_st = 1; m_sc = 0; m_t = 0; m_nh = 0;
    end else if (m_st == 1) begin
      if (a) m_sc = (m_sc + v > SMAX) ? SMAX : m_sc + v;
      if (t) m_t = (m_t + 1 > 99 * 60 + 59) ? 99 * 60 + 59 : m_t + 1;
      if (g) begin
        m_st = 2; m_ot = 0;
        if (m_sc > m_hi) begin m_hi = m_sc; m_nh = 1; end
        else m_nh = 0;
      end
    end else if (m_st == 2) begin
      if (t) m_ot++;
    end
    if (!r) q.push_back(model_view(sh));
    else begin
      exp_t e;
      e.st = 0; e.sc = 0; e.hi = 0; e.nh = 0; e.mode = 1; e.num1 = 0; e.num2 = 0; e.en = 1;
      q.push_back(e);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit g, input bit a,
                     input int v, input bit t, input bit sh);
    @(negedge clk);
    reset = r; start = s; game_over = g; add_valid = a;
    add_value = 8'(v); sec_tick = t; show_time = sh;
    model_step(r, s, g, a, v, t, sh);
  endtask

  task automatic idle(input int n, input bit sh);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, sh);
  endtask

  // Monitor: the DUT presents a new registered view every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state", int'(state), e.st);
        check("score", int'(score), e.sc);
        check("high_score", int'(high_score), e.hi);
        check("new_high", int'(new_high), e.nh);
        check("disp_mode", int'(disp_mode), e.mode);
        check("disp_num1", int'(disp_num1), e.num1);
        if (e.mode == 0) check("disp_num2", int'(disp_num2), e.num2);
        check("disp_enable", int'(disp_enable), e.en);
      end
    end
  end

  initial begin
    bit sh;
    int wait_cnt;
    sh = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2, 0);
    // IDLE ignores game_over/add_valid; then a game begins.
    cyc(0, 0, 1, 1, 77, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(1, 0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0, 1, 200, 0, 0);
    idle(1, 0);
    // New game from PLAY, 125 ticks, then show time.
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 125; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
    idle(3, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Score 300 then game over with high 0; watch pages and blink.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 200, 0, 0);
    cyc(0, 0, 0, 1, 100, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, 5, 1, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
    end
    // Add and game_over together: 280 + 50 beats high 300.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 200, 0, 0);
    cyc(0, 0, 0, 1, 80, 0, 0);
    cyc(0, 0, 1, 1, 50, 0, 0);
    idle(2, 0);
    // Tie with high score is not a new high; enable stays on.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 255, 0, 0);
    cyc(0, 0, 0, 1, 75, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    // start + game_over in PLAY: start wins.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 40, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    idle(1, 0);
    // Timer saturation at 99:59.
    for (int i = 0; i < 6010; i++) cyc(0, 0, 0, 0, 0, 1, (i % 2) == 0);
    cyc(0, 0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    // Randomized phase with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) sh = ~sh;
      cyc($urandom_range(0, 599) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 255)), $urandom_range(0, 2) == 0, sh);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
